// File: rtl/game_level_ctrl.sv
// game_level_ctrl: level sequencing FSM (IDLE/PLAY/PAUSE/WIN/LOSE) for a three-level game.
//   Build option: define GAME_LEVEL_TIMEOUT_EN to enable the per-level frame timeout (LOSE on expiry).
//   Ports:
//     clk, resetN (async, active-low)
//     startOfFrame_i-style inputs keep legacy names: startOfFrame, startGame, levelDone (one-cycle pulses)
//     startLevel1/2/3  : registered one-cycle level-start pulses
//     INITIAL_X/Y      : savior start position decoded from levelNum
//     levelNum         : current level 1..3
//     moveEnable       : high in PLAY; gameWon in WIN; gameOver in LOSE
//     framesLeft       : remaining PLAY frames (0 when timeout is disabled)
module game_level_ctrl #(
  parameter int LEVEL_FRAMES = 1800,
  parameter int PAUSE_FRAMES = 60,
  parameter int L1_X = 64,
  parameter int L1_Y = 400,
  parameter int L2_X = 32,
  parameter int L2_Y = 64,
  parameter int L3_X = 560,
  parameter int L3_Y = 400
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startGame,
  input  logic        levelDone,
  output logic        startLevel1,
  output logic        startLevel2,
  output logic        startLevel3,
  output logic [10:0] INITIAL_X,
  output logic [10:0] INITIAL_Y,
  output logic [1:0]  levelNum,
  output logic        moveEnable,
  output logic        gameWon,
  output logic        gameOver,
  output logic [11:0] framesLeft
);
  typedef enum logic [2:0] {IDLE, PLAY, PAUSE, WIN, LOSE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  level_q, level_d;
  logic [11:0] pause_q, pause_d;
  logic [2:0]  start_q, start_d;
  logic        timeout;
  if (LEVEL_FRAMES < 1 || LEVEL_FRAMES > 4095) begin : g_bad_level_frames
    $error("LEVEL_FRAMES out of range 1..4095");
  end
  if (PAUSE_FRAMES < 1 || PAUSE_FRAMES > 4095) begin : g_bad_pause_frames
    $error("PAUSE_FRAMES out of range 1..4095");
  end
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    pause_d = pause_q;
    start_d = '0;
    case (state_q)
      IDLE, WIN, LOSE:
        if (startGame) begin
          state_d = PLAY;
          level_d = 2'd1;
          start_d = 3'b001;
        end
      PLAY:
        // levelDone outranks a simultaneous timeout
        if (levelDone) begin
          state_d = (level_q == 2'd3) ? WIN : PAUSE;
          pause_d = 12'(PAUSE_FRAMES);
        end else if (timeout) begin
          state_d = LOSE;
        end
      PAUSE:
        if (startOfFrame) begin
          pause_d = (pause_q != '0) ? pause_q - 12'd1 : '0;
          if (pause_q <= 12'd1) begin
            state_d = PLAY;
            level_d = level_q + 2'd1;
            start_d = (level_q == 2'd1) ? 3'b010 : 3'b100;
          end
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      level_q <= 2'd1;
      pause_q <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      pause_q <= pause_d;
      start_q <= start_d;
    end
`ifdef GAME_LEVEL_TIMEOUT_EN
  logic [11:0] frames_q, frames_d;
  assign timeout = startOfFrame && frames_q == 12'd1;
  // every entry into PLAY reloads; LOSE forces 0; otherwise frames tick down in PLAY and hold elsewhere
  assign frames_d = (state_d == PLAY && state_q != PLAY) ? 12'(LEVEL_FRAMES)
                  : (state_q == PLAY && state_d == LOSE) ? '0
                  : (state_q == PLAY && state_d == PLAY && startOfFrame && frames_q != '0) ? frames_q - 12'd1
                  : frames_q;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) frames_q <= '0;
    else frames_q <= frames_d;
  assign framesLeft = frames_q;
`else
  assign timeout    = 1'b0;
  assign framesLeft = '0;
`endif
  assign {startLevel3, startLevel2, startLevel1} = start_q;
  assign levelNum   = level_q;
  assign INITIAL_X  = (level_q == 2'd2) ? 11'(L2_X) : (level_q == 2'd3) ? 11'(L3_X) : 11'(L1_X);
  assign INITIAL_Y  = (level_q == 2'd2) ? 11'(L2_Y) : (level_q == 2'd3) ? 11'(L3_Y) : 11'(L1_Y);
  assign moveEnable = state_q == PLAY;
  assign gameWon    = state_q == WIN;
  assign gameOver   = state_q == LOSE;
endmodule

// File: tb/tb_game_level_ctrl.sv
// tb_game_level_ctrl: directed self-checking bench for game_level_ctrl (LEVEL_FRAMES=5, PAUSE_FRAMES=3).
module tb_game_level_ctrl;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0, start_game = 1'b0, level_done = 1'b0;
  logic s1, s2, s3, move_en, won, over;
  logic [10:0] ix, iy;
  logic [1:0] lvl;
  logic [11:0] frames;
  int n_run = 0, n_fail = 0;
`ifdef GAME_LEVEL_TIMEOUT_EN
  localparam int FR = 5;
`else
  localparam int FR = 0;
`endif
  game_level_ctrl #(.LEVEL_FRAMES(5), .PAUSE_FRAMES(3)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .startGame(start_game), .levelDone(level_done),
    .startLevel1(s1), .startLevel2(s2), .startLevel3(s3), .INITIAL_X(ix), .INITIAL_Y(iy),
    .levelNum(lvl), .moveEnable(move_en), .gameWon(won), .gameOver(over), .framesLeft(frames)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask
  task automatic pulse_done();
    level_done = 1'b1;
    tick();
    level_done = 1'b0;
  endtask
  task automatic pulse_start();
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_lvl", lvl, 1);
    chk("rst_pulses", {s1, s2, s3}, 0);
    chk("rst_move", move_en, 0);
    chk("rst_flags", {won, over}, 0);
    chk("rst_frames", frames, 0);
    resetN = 1'b1;
    tick();
    chk("idle_no_pulse", {s1, s2, s3}, 0);
    pulse_start();
    chk("l1_pulse", {s1, s2, s3}, 3'b100);
    chk("l1_xy", {ix, iy}, {11'd64, 11'd400});
    chk("l1_move", move_en, 1);
    chk("l1_frames", frames, FR);
    tick();
    chk("l1_pulse_end", {s1, s2, s3}, 0);
    pulse_start();
    chk("play_start_ignored", {s1, s2, s3, move_en}, 4'b0001);
`ifdef GAME_LEVEL_TIMEOUT_EN
    for (int i = 4; i >= 1; i--) begin
      frame();
      chk("countdown", frames, i);
    end
    frame();
    chk("timeout_over", over, 1);
    chk("timeout_move", move_en, 0);
    chk("timeout_frames", frames, 0);
    pulse_done();
    chk("lose_done_ignored", {won, over}, 2'b01);
    pulse_start();
    chk("restart_pulse", {s1, s2, s3}, 3'b100);
    chk("restart_frames", frames, 5);
`else
    repeat (4000) frame();
    chk("notimeout_move", move_en, 1);
    chk("notimeout_over", over, 0);
    chk("notimeout_frames", frames, 0);
`endif
    pulse_done();
    chk("pause_move", move_en, 0);
    frame();
    pulse_done();
    pulse_start();
    frame();
    chk("pause_hold", {s1, s2, s3, move_en}, 0);
    chk("pause_lvl", lvl, 1);
    frame();
    chk("l2_pulse", {s1, s2, s3}, 3'b010);
    chk("l2_lvl", lvl, 2);
    chk("l2_xy", {ix, iy}, {11'd32, 11'd64});
    chk("l2_move_frames", {move_en, frames}, {1'b1, 12'(FR)});
    tick();
    chk("l2_pulse_end", {s1, s2, s3}, 0);
    pulse_done();
    repeat (3) frame();
    chk("l3_pulse", {s1, s2, s3}, 3'b001);
    chk("l3_lvl", lvl, 3);
    chk("l3_xy", {ix, iy}, {11'd560, 11'd400});
`ifdef GAME_LEVEL_TIMEOUT_EN
    repeat (4) frame();
    chk("l3_last_frame", frames, 1);
`endif
    sof = 1'b1;
    level_done = 1'b1;
    tick();
    sof = 1'b0;
    level_done = 1'b0;
    chk("win_flags", {won, over}, 2'b10);
    chk("win_move", move_en, 0);
    pulse_start();
    chk("win_restart", {s1, s2, s3, won}, 4'b1000);
    chk("win_restart_lvl", lvl, 1);
    pulse_done();
    repeat (3) frame();
    pulse_done();
    frame();
    chk("pre_reset_lvl", lvl, 2);
    resetN = 1'b0;
    #2;
    chk("async_rst_lvl", lvl, 1);
    chk("async_rst_out", {s1, s2, s3, move_en, won, over}, 0);
    tick();
    resetN = 1'b1;
    tick();
    chk("release_pulses", {s1, s2, s3}, 0);
    repeat (4) frame();
    chk("release_idle", {s1, s2, s3, move_en, won, over}, 0);
    chk("release_frames", frames, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
